seq_divider: RTL
================

# seq_divider

Multi-cycle restoring integer divider that sits directly upstream of the register file write port. It accepts a divide request with a destination register address and iterates one quotient bit per clock. It then presents the quotient on a one-cycle write-back strobe to the register file, with the remainder held alongside. The core datapath stays single-cycle for all other instructions; the control unit stalls on `busy`.

## Interface
- `DATA_WIDTH`, 32, operand/result width (even, ≥ 4)
- `ADDR_WIDTH`, 5, register file address width
- `clk`  in  1  clock, rising-edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `start`  in  1  request strobe; sampled only in IDLE
- `dividend`  in  DATA_WIDTH  numerator, sampled with `start`
- `divisor`  in  DATA_WIDTH  denominator, sampled with `start`
- `dest_addr`  in  ADDR_WIDTH  destination register, sampled with `start`
- `signed_op`  in  1  signed division request; see Configuration
- `busy`  out  1  high in CALC and DONE
- `wb_en`  out  1  one-cycle register file write enable
- `wb_addr`  out  ADDR_WIDTH  latched `dest_addr`
- `wb_data`  out  DATA_WIDTH  quotient
- `rem_data`  out  DATA_WIDTH  remainder, valid with `wb_en` and held until next accepted start
- `div_by_zero`  out  1  flag, valid with `wb_en`

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE → CALC: on `start`=1 with `divisor`≠0. Latch operands and `dest_addr`, clear partial remainder, load step counter = DATA_WIDTH.
- IDLE → DONE: on `start`=1 with `divisor`=0. Set quotient = all ones, remainder = dividend, `div_by_zero`=1.
- CALC step (each clock):
  - Shift {rem, quo} left by 1.
  - Trial = rem − divisor, computed on DATA_WIDTH+1 bits.
  - If trial is non-negative: rem = trial and quo[0] = 1. Otherwise quo[0] = 0.
  - Decrement the counter.
- CALC → DONE: on the clock where the counter reaches 0.
- DONE: `wb_en`=1 for exactly one cycle, then → IDLE unconditionally.
- `start` in CALC or DONE is ignored. No queuing.
- Reset values: state IDLE; `busy`, `wb_en`, `div_by_zero` = 0; `wb_addr`, `wb_data`, `rem_data` = 0.
- Reset mid-operation aborts the division. No write-back is issued.
- `wb_addr`=0 is still strobed. Discarding writes to register 0 is the register file's responsibility.

## Timing
- Cycle 0: `start` high in IDLE, sampled at the rising edge ending cycle 0.
- Cycles 1..DATA_WIDTH: CALC, `busy`=1.
- Cycle DATA_WIDTH+1: DONE, `wb_en`=1. Outputs are registered and stable for the whole cycle.
- Cycle DATA_WIDTH+2: IDLE, `busy`=0; a new `start` is accepted in this cycle.
- Divide-by-zero: `wb_en` in cycle 1, IDLE in cycle 2.
- Initiation interval: DATA_WIDTH+2 cycles normal, 2 cycles divide-by-zero.
- `busy` is registered; it rises in the cycle after `start` is accepted. The controller holds the PC from the issue cycle using `start`.

## Configuration
- Macro: `SEQ_DIVIDER_SIGNED_EN`.
- Defined, `signed_op`=1:
  - Operands are converted to magnitudes before iteration.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - MIN/−1 yields quotient MIN, remainder 0.
  - Divide-by-zero yields quotient −1 (all ones), remainder = dividend.
  - Sign fix-up happens on entry to DONE, adding no cycles.
- Defined, `signed_op`=0: unsigned.
- Not defined: `signed_op` is ignored and all operations are unsigned; sign logic is absent.

## Structure
- Package `div_pkg`: state enum (IDLE, CALC, DONE), counter width constant `$clog2(DATA_WIDTH+1)`, default width constants.
- Sub-module `div_step`: combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once inside the FSM datapath.

## Test plan
- Unsigned: 100 / 7, `dest_addr`=9 → `wb_en` in cycle 33 (DATA_WIDTH=32) with `wb_addr`=9, `wb_data`=14, `rem_data`=2, `div_by_zero`=0.
- Divide-by-zero: 0x1234 / 0 → `wb_en` in cycle 1, `wb_data`=0xFFFFFFFF, `rem_data`=0x1234, `div_by_zero`=1.
- Signed (macro defined): −7 / 2 → `wb_data`=0xFFFFFFFD (−3), `rem_data`=0xFFFFFFFF (−1).
- Signed overflow: 0x80000000 / 0xFFFFFFFF → `wb_data`=0x80000000, `rem_data`=0.
- Busy handling: second `start` (50/5) in cycle 10 is ignored. Only one `wb_en` pulse occurs, carrying the first result, and `start` issued in cycle 34 is accepted.
- Reset abort: `rst`=0 in cycle 15 → `busy`, `wb_en`, `wb_data` read 0 immediately. No `wb_en` pulse occurs after `rst` returns to 1.

Source files
------------

// File: rtl/div_pkg.sv
//------------------------------------------------------------------------------
// Module  : div_pkg
// Brief   : Shared state encoding and width constants for the sequential divider.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package div_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_CNT_WIDTH  = $clog2(DEF_DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Step counter must hold the value DATA_WIDTH itself, hence the +1.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
//------------------------------------------------------------------------------
// Module  : div_step
// Brief   : One combinational restoring-division step on {rem, quo}.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_step
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] quo,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_nxt,
    output logic [DATA_WIDTH-1:0] quo_nxt
);

    logic [DATA_WIDTH:0] w_shift;
    logic [DATA_WIDTH:0] w_trial;

    // rem < divisor on entry, so the shifted value and the trial difference
    // both fit in DATA_WIDTH+1 bits and bit DATA_WIDTH is a valid sign.
    assign w_shift = {rem, quo[DATA_WIDTH-1]};
    assign w_trial = w_shift - {1'b0, divisor};

    assign rem_nxt = w_trial[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0] : w_trial[DATA_WIDTH-1:0];
    assign quo_nxt = {quo[DATA_WIDTH-2:0], ~w_trial[DATA_WIDTH]};

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// Module  : seq_divider
// Brief   : Multi-cycle restoring divider feeding the register file write port.
//           Optional signed support via macro SEQ_DIVIDER_SIGNED_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic [ADDR_WIDTH-1:0] dest_addr,
    input  logic                  signed_op,
    output logic                  busy,
    output logic                  wb_en,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] rem_data,
    output logic                  div_by_zero
);

    localparam int CNT_W = cnt_width(DATA_WIDTH);

    div_state_t            r_state;
    div_state_t            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_div;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic [DATA_WIDTH-1:0] r_rem_data;
    logic                  r_dbz;

    logic [DATA_WIDTH-1:0] w_step_rem;
    logic [DATA_WIDTH-1:0] w_step_quo;
    logic [DATA_WIDTH-1:0] w_dvd_mag;
    logic [DATA_WIDTH-1:0] w_dvs_mag;
    logic [DATA_WIDTH-1:0] w_q_fix;
    logic [DATA_WIDTH-1:0] w_r_fix;
    logic                  w_accept;
    logic                  w_zero;
    logic                  w_last;

    assign w_accept = (r_state == IDLE) && start;
    assign w_zero   = (divisor == '0);
    assign w_last   = (r_state == CALC) && (r_cnt == CNT_W'(1));

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic w_dvd_neg;
    logic w_dvs_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_dvd_neg = signed_op & dividend[DATA_WIDTH-1];
    assign w_dvs_neg = signed_op & divisor[DATA_WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;

    // Fix-up is applied to the final step output so DONE costs no extra cycle.
    assign w_q_fix = r_neg_q ? -w_step_quo : w_step_quo;
    assign w_r_fix = r_neg_r ? -w_step_rem : w_step_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end
    end
`else
    logic w_unused_signed_op;

    assign w_unused_signed_op = signed_op;
    assign w_dvd_mag          = dividend;
    assign w_dvs_mag          = divisor;
    assign w_q_fix            = w_step_quo;
    assign w_r_fix            = w_step_rem;
`endif

    div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem     (r_rem),
        .quo     (r_quo),
        .divisor (r_div),
        .rem_nxt (w_step_rem),
        .quo_nxt (w_step_quo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        wb_en       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                wb_en       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wb_data  <= '0;
            r_rem_data <= '0;
            r_dbz      <= 1'b0;
        end else if (w_accept) begin
            r_addr <= dest_addr;
            if (w_zero) begin
                r_wb_data  <= '1;
                r_rem_data <= dividend;
                r_dbz      <= 1'b1;
            end else begin
                r_rem <= '0;
                r_quo <= w_dvd_mag;
                r_div <= w_dvs_mag;
                r_cnt <= CNT_W'(DATA_WIDTH);
                r_dbz <= 1'b0;
            end
        end else if (r_state == CALC) begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_wb_data  <= w_q_fix;
                r_rem_data <= w_r_fix;
            end
        end
    end

    assign wb_addr     = r_addr;
    assign wb_data     = r_wb_data;
    assign rem_data    = r_rem_data;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire
